spi_upload: RTL and testbench
=============================

SPI_UPLOAD -- requirements
Module: spi_upload

Interface
REQ-001 Parameter FRAME_W, default 16: SPI frame length in bits.
REQ-002 Parameter CLK_DIV, default 4: clock_20 cycles per spi_clk period; even value, minimum 2.
REQ-003 Parameter GAP_CYC, default 4: clock_20 cycles with spi_en low between frames.
REQ-004 clock_20  input  1: single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1: reset, asynchronous and active-low.
REQ-006 start  input  1: upload request; rising edge triggers an upload.
REQ-007 nrg  input  4: number of register frames to upload (0..15).
REQ-008 spi_clk  output  1: serial clock, idle low.
REQ-009 spi_en  output  1: frame enable, active-high, high for the duration of each frame.
REQ-010 spi_dat  output  1: serial data, MSB first.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-012 start SHALL be registered into start_q; a rising edge is start=1 and start_q=0 at a clock edge.
REQ-013 States SHALL be IDLE, SETUP, SHIFT, GAP.
- IDLE: spi_clk=0, spi_en=0, spi_dat=0.
REQ-014 In IDLE, a start rising edge SHALL latch nrg into cnt_total, clear frame index idx=0, and go to SETUP if nrg!=0.
- If nrg==0, the block stays in IDLE.
REQ-015 SETUP SHALL last CLK_DIV/2 cycles (2 by default), with spi_en=1, spi_clk=0 and spi_dat = frame bit FRAME_W-1.
REQ-016 SHIFT SHALL run FRAME_W bit periods of CLK_DIV cycles each.
- spi_clk is high for the first half of each period and low for the second half.
- spi_dat changes only on the cycle where spi_clk goes high-to-low, and then presents the next bit.
- The receiver samples on the spi_clk rising edge.
REQ-017 After the low half of the last bit, the FSM SHALL enter GAP with spi_en=0, spi_clk=0 and spi_dat=0 for GAP_CYC cycles.
REQ-018 At the end of GAP, idx SHALL increment.
- If idx+1 < cnt_total, go to SETUP for the next frame; otherwise go to IDLE.
REQ-019 The frame word for index i SHALL be {1'b1 write bit, 7-bit address = i, 8-bit data = ROM[i]}.
- Default ROM[i] = {4'h5, i[3:0]}, so frame 0 = 16'h8050 and frame 7 = 16'h8757.
REQ-020 Default timing: spi_en is high for 66 cycles per frame; each frame slot is 70 cycles.
- nrg=8 completes in 560 cycles after the SETUP entry.
REQ-021 start edges arriving while not in IDLE SHALL be ignored.
- start held high SHALL NOT retrigger; it must return low first.
REQ-022 nrg changes during an upload SHALL have no effect; only the value latched at the start edge is used.
REQ-023 With nrg=15, 15 frames (idx 0..14) SHALL be sent; idx never wraps past cnt_total.

Reset
REQ-024 reset_n low SHALL immediately force: state IDLE, spi_clk=0, spi_en=0, spi_dat=0, idx=0, cnt_total=0, bit and cycle counters 0, start_q=0.
REQ-025 Reset asserted mid-frame SHALL abort the upload; after release the block waits in IDLE for a new start edge.
REQ-026 If start is already high when reset releases, the first clock SHALL load start_q=1 without triggering.

Configuration
REQ-027 Macro SPI_UPLOAD_DONE_EN, when defined, SHALL add output done (1 bit) that pulses high for exactly one cycle on the GAP-to-IDLE transition of the final frame.
- done is 0 in reset.
- With nrg=0, done SHALL pulse one cycle after the start edge.
- Without the macro, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-028 Package spi_upload_pkg SHALL hold the state enum type, FRAME_W/CLK_DIV/GAP_CYC defaults, the write-bit constant and the 16x8 ROM default table.
REQ-029 Sub-module spi_reg_rom SHALL provide a combinational 4-bit index to 8-bit data lookup of the package table.

Verification
REQ-030 nrg=8, start 0->1 after reset: 8 frames shift out 16'h8050..16'h8757; spi_en low for 4 cycles between frames; 560 cycles total.
REQ-031 nrg=0, start edge: spi_en stays 0; done pulses once when SPI_UPLOAD_DONE_EN is defined.
REQ-032 start held high after the upload completes: no second upload; a start low-high pulse starts a new one.
REQ-033 reset_n low during frame 3, bit 9: all outputs are 0 immediately; no activity until the next start edge.
REQ-034 nrg changed from 2 to 15 mid-upload: exactly 2 frames are sent.
REQ-035 Per-bit check, default parameters: spi_dat is stable from 2 cycles before through 2 cycles after each spi_clk rising edge.

Source files
------------

// File: rtl/spi_upload_pkg.sv
// Shared types, default parameters and the register ROM table for spi_upload.
// The optional done output is controlled by the SPI_UPLOAD_DONE_EN macro.
package spi_upload_pkg;

    localparam int FRAME_W_DEF = 16;
    localparam int CLK_DIV_DEF = 4;
    localparam int GAP_CYC_DEF = 4;

    // Leading bit of every frame marks the transfer as a register write.
    localparam logic WR_BIT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // Default register contents: upper nibble 5, lower nibble = register index.
    localparam logic [7:0] ROM_TABLE [16] = '{
        8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57,
        8'h58, 8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F
    };

    // Frame layout: write bit, 7-bit address (the register index), 8-bit data.
    function automatic logic [15:0] build_frame(input logic [3:0] i, input logic [7:0] d);
        return {WR_BIT, 3'b000, i, d};
    endfunction

endpackage

// File: rtl/spi_upload_rom.sv
// Combinational register-data lookup from the package ROM table.
module spi_reg_rom
    import spi_upload_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] data
);

    // Pure table lookup; no state.
    always_comb begin
        data = ROM_TABLE[idx];
    end

endmodule

// File: rtl/spi_upload.sv
// SPI register uploader: on a start rising edge, shifts nrg register frames
// out MSB first, each framed by spi_en and separated by a fixed idle gap.
// Define SPI_UPLOAD_DONE_EN to add a one-cycle done pulse at upload end.
//
// Handshake: start is a level request; only a 0->1 transition seen while
// IDLE launches an upload, and nrg is sampled only on that same edge.
module spi_upload
    import spi_upload_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic       clock_20,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] nrg,
    output logic       spi_clk,
    output logic       spi_en,
    output logic       spi_dat,
    output logic [1:0] dbg_state
`ifdef SPI_UPLOAD_DONE_EN
    ,
    output logic       done
`endif
);

    localparam int HALF    = CLK_DIV / 2;
    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W);

    state_t             state;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [3:0]         idx;
    logic [3:0]         cnt_total;
    logic               start_q;
    logic               armed;
    logic               start_rise;

    logic [3:0]         rom_idx;
    logic [7:0]         rom_data;
    logic [FRAME_W-1:0] frame_word;
    logic [BIT_W-1:0]   next_pos;
    logic               next_bit;
    logic               gap_end;
    logic               more_frames;

    spi_reg_rom u_rom (
        .idx  (rom_idx),
        .data (rom_data)
    );

    assign dbg_state = state;

    // Start edge detection; armed blocks a trigger on the first clock after
    // reset so a start already held high at release is not taken as an edge.
    always_ff @(posedge clock_20 or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= start;
            armed   <= 1'b1;
        end
    end

    // Frame word selection: in GAP the next frame is looked up so its MSB
    // is ready on the GAP->SETUP transition; IDLE always prepares frame 0.
    always_comb begin
        start_rise  = start & ~start_q & armed;
        rom_idx     = idx;
        if (state == S_IDLE) begin
            rom_idx = 4'd0;
        end else if (state == S_GAP) begin
            rom_idx = idx + 4'd1;
        end
        frame_word  = FRAME_W'(build_frame(rom_idx, rom_data));
        next_pos    = BIT_W'(FRAME_W - 2) - bit_cnt;
        next_bit    = (bit_cnt == BIT_W'(FRAME_W - 1)) ? 1'b0 : frame_word[next_pos];
        gap_end     = (state == S_GAP) && (cyc_cnt == CNT_W'(GAP_CYC - 1));
        more_frames = ({1'b0, idx} + 5'd1) < {1'b0, cnt_total};
    end

    // Main FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clock_20 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            idx       <= 4'd0;
            cnt_total <= 4'd0;
            spi_clk   <= 1'b0;
            spi_en    <= 1'b0;
            spi_dat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    spi_clk <= 1'b0;
                    spi_en  <= 1'b0;
                    spi_dat <= 1'b0;
                    if (start_rise) begin
                        cnt_total <= nrg;
                        idx       <= 4'd0;
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                        if (nrg != 4'd0) begin
                            state   <= S_SETUP;
                            spi_en  <= 1'b1;
                            spi_dat <= frame_word[FRAME_W-1];
                        end
                    end
                end

                S_SETUP: begin
                    if (cyc_cnt == CNT_W'(HALF - 1)) begin
                        state   <= S_SHIFT;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        spi_clk <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (cyc_cnt == CNT_W'(HALF - 1)) begin
                        // Falling edge: present the following bit.
                        spi_clk <= 1'b0;
                        spi_dat <= next_bit;
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end else if (cyc_cnt == CNT_W'(CLK_DIV - 1)) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                            state   <= S_GAP;
                            spi_en  <= 1'b0;
                            spi_dat <= 1'b0;
                            spi_clk <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            spi_clk <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (gap_end) begin
                        cyc_cnt <= '0;
                        idx     <= idx + 4'd1;
                        if (more_frames) begin
                            state   <= S_SETUP;
                            spi_en  <= 1'b1;
                            spi_dat <= frame_word[FRAME_W-1];
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_UPLOAD_DONE_EN
    // One-cycle completion pulse: end of the last gap, or immediately for nrg==0.
    always_ff @(posedge clock_20 or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= ((state == S_IDLE) && start_rise && (nrg == 4'd0)) ||
                    (gap_end && !more_frames);
        end
    end
`endif

endmodule

// File: tb/tb_spi_upload.sv
// Directed bench for spi_upload: frame contents, timing, start-edge rules,
// nrg latching, mid-frame reset and the optional done pulse
// (SPI_UPLOAD_DONE_EN).
module tb_spi_upload;

    logic       clock_20 = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] nrg;
    logic       spi_clk;
    logic       spi_en;
    logic       spi_dat;
    logic [1:0] dbg_state;
`ifdef SPI_UPLOAD_DONE_EN
    logic       done;
`endif

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [15:0] exp_q[$];

    // Clock
    always #5 clock_20 = ~clock_20;

    spi_upload dut (
        .clock_20  (clock_20),
        .reset_n   (reset_n),
        .start     (start),
        .nrg       (nrg),
        .spi_clk   (spi_clk),
        .spi_en    (spi_en),
        .spi_dat   (spi_dat),
        .dbg_state (dbg_state)
`ifdef SPI_UPLOAD_DONE_EN
        ,
        .done      (done)
`endif
    );

    task automatic step();
        @(negedge clock_20);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Wait (bounded) for spi_en, then record the frame until spi_en drops.
    // Bits are taken at spi_clk rising edges; a bit counts as unstable if
    // spi_dat differs within two cycles either side of its rising edge.
    task automatic collect_frame(output logic [15:0] word, output int en_len,
                                 output int unstable, output int t_first);
        logic c [0:127];
        logic d [0:127];
        int   t = 0;
        int   n = 0;
        word     = 16'h0;
        unstable = 0;
        while (spi_en !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        t_first = cyc;
        while (spi_en === 1'b1 && n < 128) begin
            c[n] = spi_clk;
            d[n] = spi_dat;
            n++;
            step();
        end
        en_len = n;
        for (int k = 0; k < n; k++) begin
            if (c[k] === 1'b1 && (k == 0 || c[k-1] === 1'b0)) begin
                word = {word[14:0], d[k]};
                if (k < 2 || k + 1 >= n) unstable++;
                else if (d[k-2] !== d[k] || d[k-1] !== d[k] || d[k+1] !== d[k]) unstable++;
            end
        end
    endtask

    // Count low spi_en cycles until it rises again; saturates at 30.
    task automatic measure_gap(output int g);
        g = 0;
        while (spi_en !== 1'b1 && g < 30) begin
            g++;
            step();
        end
    endtask

    // Count cycles with spi_en high over a window.
    task automatic count_en(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (spi_en !== 1'b0) hi++;
            step();
        end
    endtask

    initial begin
        logic [15:0] w;
        int len, uns, tf, t0, g, hi;

        // Reset
        reset_n = 1'b0;
        start   = 1'b0;
        nrg     = 4'd0;
        steps(3);
        check("rst spi_clk", spi_clk, 0);
        check("rst spi_en", spi_en, 0);
        check("rst spi_dat", spi_dat, 0);
        check("rst state", dbg_state, 0);
`ifdef SPI_UPLOAD_DONE_EN
        check("rst done", done, 0);
`endif
        reset_n = 1'b1;
        steps(3);

        // nrg=8: frames 8050..8757, 66-cycle frames, 4-cycle gaps, 560 total
        t0  = 0;
        nrg = 4'd8;
        start = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h8050 + 16'h0101 * i[15:0]);
        for (int f = 0; f < 8; f++) begin
            collect_frame(w, len, uns, tf);
            if (f == 0) t0 = tf;
            check("n8 word", w, exp_q.pop_front());
            check("n8 en_len", len, 66);
            check("n8 stable", uns, 0);
            if (f < 7) begin
                measure_gap(g);
                check("n8 gap", g, 4);
            end
        end
        steps(4);
        check("n8 span", cyc - t0, 560);
`ifdef SPI_UPLOAD_DONE_EN
        check("n8 done pulse", done, 1);
        step();
        check("n8 done low", done, 0);
`endif
        // start still held high: no retrigger
        count_en(40, hi);
        check("held start idle", hi, 0);

        // nrg=2 then changed to 15 mid-upload, and a start edge during GAP
        start = 1'b0;
        nrg   = 4'd2;
        step();
        start = 1'b1;
        collect_frame(w, len, uns, tf);
        check("n2 word0", w, 16'h8050);
        check("n2 en_len0", len, 66);
        measure_gap(g);
        check("n2 gap", g, 4);
        nrg   = 4'd15;
        start = 1'b0;
        collect_frame(w, len, uns, tf);
        check("n2 word1", w, 16'h8151);
        start = 1'b1;
        measure_gap(g);
        check("n2 no third frame", g, 30);

        // nrg=15: frames idx 0..14, no sixteenth
        start = 1'b0;
        step();
        start = 1'b1;
        for (int i = 0; i < 15; i++) exp_q.push_back(16'h8050 + 16'h0101 * i[15:0]);
        for (int f = 0; f < 15; f++) begin
            collect_frame(w, len, uns, tf);
            check("n15 word", w, exp_q.pop_front());
            check("n15 stable", uns, 0);
            measure_gap(g);
            if (f < 14) check("n15 gap", g, 4);
            else check("n15 no wrap", g, 30);
        end

        // Reset during frame 3, bit 9
        start = 1'b0;
        nrg   = 4'd5;
        step();
        start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            collect_frame(w, len, uns, tf);
            check("r5 word", w, 16'h8050 + 16'h0101 * f[15:0]);
            measure_gap(g);
        end
        steps(39);
        check("mid bit9 en", spi_en, 1);
        check("mid bit9 clk", spi_clk, 1);
        check("mid bit9 dat", spi_dat, 1);
        reset_n = 1'b0;
        #1;
        check("async rst clk", spi_clk, 0);
        check("async rst en", spi_en, 0);
        check("async rst dat", spi_dat, 0);
        check("async rst state", dbg_state, 0);
        steps(2);
        // Release with start already high: must not trigger
        reset_n = 1'b1;
        count_en(30, hi);
        check("post rst idle", hi, 0);

        // nrg=0: no frame, done pulse one cycle after the edge
        start = 1'b0;
        nrg   = 4'd0;
        step();
        start = 1'b1;
        step();
`ifdef SPI_UPLOAD_DONE_EN
        check("n0 done pulse", done, 1);
        step();
        check("n0 done low", done, 0);
`endif
        count_en(20, hi);
        check("n0 no frame", hi, 0);

        // nrg=1: single frame then idle
        start = 1'b0;
        nrg   = 4'd1;
        step();
        start = 1'b1;
        collect_frame(w, len, uns, tf);
        check("n1 word", w, 16'h8050);
        check("n1 en_len", len, 66);
        measure_gap(g);
        check("n1 single", g, 30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
